// File: rtl/trunc_restore_if.sv
// Stream bundle for trunc_restore: truncated-word input side, reconstructed-value output side.
interface trunc_restore_if #(
    parameter int unsigned N     = 5,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_signal;
    logic [N-1:0]     in_truncator;
    logic             in_load;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_value;
    logic [N-1:0]     out_mask;
    logic [CNT_W-1:0] beat_count;

    modport master (
        output in_valid, in_signal, in_truncator, in_load, out_ready,
        input  in_ready, out_valid, out_value, out_mask, beat_count
    );

    modport slave (
        input  in_valid, in_signal, in_truncator, in_load, out_ready,
        output in_ready, out_valid, out_value, out_mask, beat_count
    );
endinterface

// File: rtl/trunc_restore.sv
// Rebuilds full values from truncated words: masked-off upper bits come from the last
// reconstructed value. Two-stage valid/ready pipeline.
module trunc_restore #(
    parameter int unsigned N     = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    trunc_restore_if.slave  bus
);
    logic             s1_valid_q, s1_valid_d;
    logic [N-1:0]     s1_signal_q, s1_signal_d;
    logic [N-1:0]     s1_mask_q, s1_mask_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     out_value_q, out_value_d;
    logic [N-1:0]     out_mask_q, out_mask_d;
    logic [N-1:0]     hist_q, hist_d;
    logic [CNT_W-1:0] beat_count_q, beat_count_d;

    logic [N-1:0]     in_mask;
    logic [N-1:0]     merged;
    logic             adv2;
    logic             in_ready;
    logic             accept;

    // Prefix OR from the LSB: every bit at/above the lowest set truncator bit is masked.
    always_comb begin
        in_mask    = '0;
        in_mask[0] = bus.in_truncator[0];
        for (int unsigned i = 1; i < N; i++) begin
            in_mask[i] = in_mask[i-1] | bus.in_truncator[i];
        end
        if (bus.in_load) begin
            in_mask = '0;
        end
    end

    assign adv2     = s1_valid_q & (~out_valid_q | bus.out_ready);
    assign in_ready = ~s1_valid_q | adv2;
    assign accept   = bus.in_valid & in_ready;
    assign merged   = (s1_signal_q & ~s1_mask_q) | (hist_q & s1_mask_q);

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_signal_d  = s1_signal_q;
        s1_mask_d    = s1_mask_q;
        out_valid_d  = out_valid_q;
        out_value_d  = out_value_q;
        out_mask_d   = out_mask_q;
        hist_d       = hist_q;
        beat_count_d = beat_count_q;

        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_signal_d = bus.in_signal;
            s1_mask_d   = in_mask;
        end else if (adv2) begin
            s1_valid_d  = 1'b0;
        end

        // History follows stage-2 loads so back-to-back beats chain without a bubble.
        if (adv2) begin
            out_valid_d  = 1'b1;
            out_value_d  = merged;
            out_mask_d   = s1_mask_q;
            hist_d       = merged;
            beat_count_d = beat_count_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_signal_q  <= '0;
            s1_mask_q    <= '0;
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            out_mask_q   <= '0;
            hist_q       <= '0;
            beat_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_signal_q  <= s1_signal_d;
            s1_mask_q    <= s1_mask_d;
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            out_mask_q   <= out_mask_d;
            hist_q       <= hist_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_value  = out_value_q;
    assign bus.out_mask   = out_mask_q;
    assign bus.beat_count = beat_count_q;
endmodule

// File: tb/tb_trunc_restore.sv
// Self-checking bench for trunc_restore: vector table, hand sequences for flow-control
// corners, and a randomized stream against a mask/history reference model.
module tb_trunc_restore;
    typedef struct packed {
        logic [4:0] value;
        logic [4:0] mask;
    } exp_t;

    typedef struct {
        bit         load;
        logic [4:0] sig;
        logic [4:0] tr;
        logic [4:0] value;
        logic [4:0] mask;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    trunc_restore_if #(.N(5), .CNT_W(16)) bus ();

    trunc_restore #(.N(5), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         accepted = 0;
    int         delivered = 0;
    int         win = 0;
    int         first_out_win = -1;
    int         last_out_win = -1;
    bit         use_model = 1'b1;
    bit         prev_stall = 1'b0;
    logic [4:0] prev_val, prev_mask;
    logic [4:0] last_val = '0;
    logic [4:0] hist_m = '0;
    exp_t       exp_q[$];
    vec_t       tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Mask = every bit position at or above the lowest set truncator bit.
    function automatic logic [4:0] model_mask(input logic [4:0] tr, input bit ld);
        logic [4:0] low;
        if (ld || tr == 5'd0) return 5'd0;
        low = tr & (~tr + 5'd1);
        return ~(low - 5'd1);
    endfunction

    // One clock window: inputs were set at posedge+1; observe at posedge+2.
    task automatic cycle();
        exp_t e;
        logic [4:0] m, v;
        #1;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                accepted++;
                if (use_model) begin
                    m = model_mask(bus.in_truncator, bus.in_load);
                    v = (bus.in_signal & ~m) | (hist_m & m);
                    hist_m = v;
                    exp_q.push_back('{value: v, mask: m});
                end
            end
            if (prev_stall)
                check("stall_hold", {bus.out_valid, bus.out_value, bus.out_mask},
                      {1'b1, prev_val, prev_mask});
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(bus.out_value), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_value", 32'(bus.out_value), 32'(e.value));
                    check("out_mask", 32'(bus.out_mask), 32'(e.mask));
                end
                delivered++;
                last_val = bus.out_value;
                if (first_out_win < 0) first_out_win = win;
                last_out_win = win;
            end
            prev_stall = bus.out_valid & ~bus.out_ready;
            prev_val   = bus.out_value;
            prev_mask  = bus.out_mask;
        end
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            hist_m     = '0;
            prev_stall = 1'b0;
        end
        #1;
        win++;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        accepted = 0;
        delivered = 0;
        first_out_win = -1;
    endtask

    task automatic send(input bit ld, input logic [4:0] s, input logic [4:0] t);
        int a0 = accepted;
        bus.in_valid     = 1'b1;
        bus.in_load      = ld;
        bus.in_signal    = s;
        bus.in_truncator = t;
        for (int k = 0; k < 50 && accepted == a0; k++) cycle();
        check("send_accepted", accepted - a0, 1);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) cycle();
        check("drain_empty", exp_q.size(), 0);
        cycle();
    endtask

    task automatic rand_beat();
        bus.in_load      = ($urandom_range(7) == 0);
        bus.in_signal    = 5'($urandom);
        bus.in_truncator = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
    endtask

    initial begin
        int acc_win;
        int a0;
        bit pending;

        tbl[0] = '{1'b1, 5'b10110, 5'b00000, 5'b10110, 5'b00000};
        tbl[1] = '{1'b0, 5'b00001, 5'b00100, 5'b10101, 5'b11100};
        tbl[2] = '{1'b1, 5'b10000, 5'b00000, 5'b10000, 5'b00000};
        tbl[3] = '{1'b0, 5'b00011, 5'b01000, 5'b10011, 5'b11000};
        tbl[4] = '{1'b0, 5'b00001, 5'b00010, 5'b10011, 5'b11110};
        tbl[5] = '{1'b0, 5'b01010, 5'b00000, 5'b01010, 5'b00000};
        tbl[6] = '{1'b0, 5'b00000, 5'b00001, 5'b01010, 5'b11111};
        tbl[7] = '{1'b0, 5'b11111, 5'b10000, 5'b01111, 5'b10000};
        tbl[8] = '{1'b1, 5'b11001, 5'b00111, 5'b11001, 5'b00000};
        tbl[9] = '{1'b0, 5'b00110, 5'b00110, 5'b11000, 5'b11110};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_load = 1'b0;
        bus.in_signal = '0;
        bus.in_truncator = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        do_reset();

        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_value", bus.out_value, 0);
        check("rst_out_mask", bus.out_mask, 0);
        check("rst_beat_count", bus.beat_count, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Vector table, streamed back-to-back.
        use_model = 1'b0;
        bus.out_ready = 1'b1;
        foreach (tbl[i]) exp_q.push_back('{value: tbl[i].value, mask: tbl[i].mask});
        foreach (tbl[i]) send(tbl[i].load, tbl[i].sig, tbl[i].tr);
        drain();
        check("tbl_delivered", delivered, 10);
        use_model = 1'b1;

        // Repeat beats: no bubbles, 2-cycle latency.
        do_reset();
        bus.out_ready = 1'b1;
        acc_win = win;
        send(1'b1, 5'b01111, 5'b00000);
        for (int k = 0; k < 5; k++) send(1'b0, 5'b00000, 5'b00001);
        drain();
        check("rep_value", last_val, 5'b01111);
        check("rep_latency", first_out_win - acc_win, 2);
        check("rep_no_bubble", last_out_win - first_out_win, 5);
        check("rep_beat_count", bus.beat_count, 6);

        // Downstream stall with input held valid.
        do_reset();
        bus.out_ready = 1'b0;
        rand_beat();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a0 = accepted;
            cycle();
            if (accepted != a0) rand_beat();
        end
        check("stall_accepted", accepted, 2);
        check("stall_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50 && accepted < 5; k++) begin
            a0 = accepted;
            cycle();
            if (accepted != a0) rand_beat();
        end
        drain();
        check("stall_delivered", delivered, 5);

        // Reset with two beats in flight.
        do_reset();
        bus.out_ready = 1'b0;
        send(1'b1, 5'b11111, 5'b00000);
        send(1'b0, 5'b01010, 5'b00011);
        bus.in_valid = 1'b0;
        cycle();
        do_reset();
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_beat_count", bus.beat_count, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        send(1'b0, 5'b00101, 5'b10000);
        drain();
        check("post_rst_value", last_val, 5'b00101);

        // Random stream with random stalls.
        do_reset();
        pending = 1'b0;
        for (int k = 0; k < 60000 && accepted < 10000; k++) begin
            bus.out_ready = ($urandom_range(9) < 7);
            if (!pending && $urandom_range(3) != 0) begin
                rand_beat();
                bus.in_valid = 1'b1;
                pending = 1'b1;
            end
            a0 = accepted;
            cycle();
            if (accepted != a0) begin
                pending = 1'b0;
                bus.in_valid = 1'b0;
            end
        end
        bus.out_ready = 1'b1;
        drain();
        check("rand_accepted", accepted, 10000);
        check("rand_delivered", delivered, 10000);
        check("rand_beat_count", bus.beat_count, delivered % 65536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
